ptr_feeder: RTL and testbench
=============================

PTR_FEEDER -- requirements
Module: ptr_feeder

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state changes on its rising edge.
REQ-002 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port h_write, input, 1, host register write strobe, one cycle per access.
REQ-004 SHALL have port h_read, input, 1, host register read strobe.
REQ-005 SHALL have port h_address, input, 2, register select: 0 DATA, 1 CTRL, 2 DELAY, 3 STATUS.
REQ-006 SHALL have port h_writedata, input, 32, host write data.
REQ-007 SHALL have port h_readdata, output, 32, registered read data, valid the cycle after h_read.
REQ-008 SHALL have port fe_req, input, 1, reader front-end request for the next tape frame.
REQ-009 SHALL have port fe_write, output, 1, one-cycle frame strobe to the reader's s_write.
REQ-010 SHALL have port fe_writedata, output, 32, frame in bits 7:0, bits 31:8 zero; drives the reader's s_writedata.
REQ-011 SHALL have port irq, output, 1, low-water interrupt to host.

Function
REQ-012 SHALL buffer frames in a 16-entry x 8-bit FIFO with 5-bit count 0..16; pointers wrap modulo 16.
REQ-013 Write to DATA SHALL push h_writedata[7:0]; push when full SHALL drop the byte and set sticky OVF.
REQ-014 CTRL bit0 RUN SHALL enable serving; CTRL bit1 FLUSH (self-clearing) SHALL empty the FIFO and clear OVF/UNDR; CTRL bit2 SHALL clear OVF/UNDR only.
REQ-015 DELAY (16 bits, default 0) SHALL set pacing cycles inserted before each frame.
REQ-016 STATUS read SHALL return count[4:0], bit5 EMPTY, bit6 FULL, bit7 OVF, bit8 UNDR, bit9 IRQ pending, bits 12:10 FSM state code.
REQ-017 FSM states IDLE(0), PACE(1), ISSUE(2), STARVE(3).
REQ-018 IDLE->PACE when RUN=1 and fe_req sampled high while previously sampled low; pacing counter loaded with DELAY.
REQ-019 PACE SHALL decrement counter each cycle; at zero -> ISSUE if FIFO non-empty, else STARVE with UNDR set.
REQ-020 ISSUE SHALL assert fe_write exactly one cycle with head byte, pop it, return IDLE.
REQ-021 STARVE -> ISSUE on first cycle FIFO becomes non-empty; any state -> IDLE when RUN=0, no write, no pop.
REQ-022 With DELAY=D, fe_write SHALL assert exactly D+2 cycles after the first edge sampling fe_req high.
REQ-023 fe_req edges arriving outside IDLE SHALL be ignored (no queuing).
REQ-024 Simultaneous push and pop SHALL leave count unchanged; push when full coinciding with pop SHALL be accepted.
REQ-025 FLUSH coincident with push or pop: flush wins, count becomes 0, FSM in ISSUE aborts to IDLE without fe_write.

Reset
REQ-026 reset low SHALL immediately force IDLE, FIFO empty, RUN=0, DELAY=0, OVF=UNDR=0, fe_write=0, fe_writedata=0, h_readdata=0, irq=0; mid-frame reset discards pending frame.

Configuration
REQ-027 With PTR_FEEDER_IRQ_EN defined, irq SHALL be registered high while RUN=1 and count<=4, low otherwise; DELAY[31:16] unused.
REQ-028 Without PTR_FEEDER_IRQ_EN, irq SHALL be constant 0 and STATUS bit9 SHALL read 0; all else identical.

Structure
REQ-029 Shared package ptr_feeder_pkg SHALL hold register address constants, CTRL/STATUS bit positions, FSM state codes, FIFO depth 16.
REQ-030 FIFO SHALL be sub-module ptr_feeder_fifo (push, pop, flush, head, count, full, empty); FSM, pacing counter and registers in ptr_feeder.

Verification
REQ-031 Push 'o372,'o373; RUN=1; DELAY=0; pulse fe_req -> fe_write at edge+2 with fe_writedata='o372; second request -> 'o373; STATUS count 0, EMPTY=1.
REQ-032 DELAY=5, one byte, fe_req -> fe_write exactly 7 cycles after edge; fe_req held high across frame yields only one frame.
REQ-033 Empty FIFO, RUN=1, fe_req -> UNDR=1, state 3; push 'o134 -> fe_write with 'o134 next cycle+1, state returns 0.
REQ-034 17 pushes -> count 16, FULL=1, OVF=1, 17th byte lost; FLUSH -> count 0, OVF 0.
REQ-035 reset low during PACE with DELAY=100 -> no fe_write, all registers default; with PTR_FEEDER_IRQ_EN, irq high at count 4, low at count 5.

Source files
------------

// File: rtl/ptr_feeder_pkg.sv
//------------------------------------------------------------------------------
// Module   : ptr_feeder_pkg
// Brief    : Shared constants, FSM state codes and status packing for ptr_feeder.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package ptr_feeder_pkg;

  localparam logic [1:0] c_addr_data   = 2'd0;
  localparam logic [1:0] c_addr_ctrl   = 2'd1;
  localparam logic [1:0] c_addr_delay  = 2'd2;
  localparam logic [1:0] c_addr_status = 2'd3;

  localparam int c_ctrl_run   = 0;
  localparam int c_ctrl_flush = 1;
  localparam int c_ctrl_clr   = 2;

  localparam int c_st_empty    = 5;
  localparam int c_st_full     = 6;
  localparam int c_st_ovf      = 7;
  localparam int c_st_undr     = 8;
  localparam int c_st_irq      = 9;
  localparam int c_st_state_lo = 10;

  localparam int c_fifo_depth    = 16;
  localparam int c_ptr_w         = 4;
  localparam int c_cnt_w         = 5;
  localparam int c_irq_low_water = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PACE   = 2'd1,
    ST_ISSUE  = 2'd2,
    ST_STARVE = 2'd3
  } feeder_state_e;

  function automatic logic [31:0] pack_status(
    input logic [c_cnt_w-1:0] cnt,
    input logic               emp,
    input logic               ful,
    input logic               ovf,
    input logic               undr,
    input logic               irq_pend,
    input logic [1:0]         st
  );
    logic [31:0] s;
    s                     = '0;
    s[c_cnt_w-1:0]        = cnt;
    s[c_st_empty]         = emp;
    s[c_st_full]          = ful;
    s[c_st_ovf]           = ovf;
    s[c_st_undr]          = undr;
    s[c_st_irq]           = irq_pend;
    s[c_st_state_lo +: 3] = {1'b0, st};
    return s;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ptr_feeder_fifo.sv
//------------------------------------------------------------------------------
// Module   : ptr_feeder_fifo
// Brief    : 16 x 8-bit frame FIFO with flush; flush overrides push and pop.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ptr_feeder_fifo
  import ptr_feeder_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               push,
  input  logic [7:0]         push_data,
  input  logic               pop,
  input  logic               flush,
  output logic [7:0]         head,
  output logic [c_cnt_w-1:0] count,
  output logic               full,
  output logic               empty
);

  logic [7:0]         r_mem [c_fifo_depth];
  logic [c_ptr_w-1:0] r_wptr;
  logic [c_ptr_w-1:0] r_rptr;
  logic [c_cnt_w-1:0] r_count;
  logic               w_do_push;
  logic               w_do_pop;

  assign full  = (r_count == c_cnt_w'(c_fifo_depth));
  assign empty = (r_count == '0);
  assign count = r_count;
  assign head  = r_mem[r_rptr];

  // A push into a full FIFO is still taken when a pop frees a slot that cycle.
  assign w_do_pop  = pop && !empty && !flush;
  assign w_do_push = push && (!full || w_do_pop) && !flush;

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr] <= push_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/ptr_feeder.sv
//------------------------------------------------------------------------------
// Module   : ptr_feeder
// Brief    : Paced paper-tape frame feeder; optional low-water irq via
//            PTR_FEEDER_IRQ_EN.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ptr_feeder
  import ptr_feeder_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        h_write,
  input  logic        h_read,
  input  logic [1:0]  h_address,
  input  logic [31:0] h_writedata,
  output logic [31:0] h_readdata,
  input  logic        fe_req,
  output logic        fe_write,
  output logic [31:0] fe_writedata,
  output logic        irq
);

  feeder_state_e      r_state;
  feeder_state_e      w_state_nxt;
  logic [15:0]        r_pace;
  logic [15:0]        w_pace_nxt;
  logic               r_run;
  logic [15:0]        r_delay;
  logic               r_ovf;
  logic               r_undr;
  logic               r_req_prev;
  logic               r_fe_write;
  logic [31:0]        r_fe_writedata;
  logic [31:0]        r_readdata;
  logic [31:0]        w_readmux;

  logic               w_req_rise;
  logic               w_push;
  logic               w_pop;
  logic               w_issue;
  logic               w_set_undr;
  logic               w_flush;
  logic               w_clr;
  logic               w_drop;
  logic               w_irq;
  logic [7:0]         w_head;
  logic [c_cnt_w-1:0] w_count;
  logic               w_full;
  logic               w_empty;
  logic               w_unused_ok;

  assign w_unused_ok = ^h_writedata[31:16];

  assign w_req_rise = fe_req && !r_req_prev;
  assign w_push     = h_write && (h_address == c_addr_data);
  assign w_flush    = h_write && (h_address == c_addr_ctrl) && h_writedata[c_ctrl_flush];
  assign w_clr      = h_write && (h_address == c_addr_ctrl) && h_writedata[c_ctrl_clr];
  assign w_drop     = w_push && w_full && !w_pop;

  ptr_feeder_fifo u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (w_push),
    .push_data (h_writedata[7:0]),
    .pop       (w_pop),
    .flush     (w_flush),
    .head      (w_head),
    .count     (w_count),
    .full      (w_full),
    .empty     (w_empty)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_pace  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pace  <= w_pace_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pace_nxt  = r_pace;
    w_pop       = 1'b0;
    w_issue     = 1'b0;
    w_set_undr  = 1'b0;
    if (!r_run) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_req_rise) begin
            w_state_nxt = ST_PACE;
            w_pace_nxt  = r_delay;
          end
        end
        ST_PACE: begin
          if (r_pace == '0) begin
            if (!w_empty) begin
              w_state_nxt = ST_ISSUE;
            end else begin
              w_state_nxt = ST_STARVE;
              w_set_undr  = 1'b1;
            end
          end else begin
            w_pace_nxt = r_pace - 1'b1;
          end
        end
        // A flush landing here aborts the frame without a strobe.
        ST_ISSUE: begin
          w_state_nxt = ST_IDLE;
          if (!w_flush && !w_empty) begin
            w_pop   = 1'b1;
            w_issue = 1'b1;
          end
        end
        ST_STARVE: begin
          if (!w_empty) w_state_nxt = ST_ISSUE;
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

`ifdef PTR_FEEDER_IRQ_EN
  logic r_irq;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_irq <= 1'b0;
    else        r_irq <= r_run && (w_count <= c_cnt_w'(c_irq_low_water));
  end
  assign w_irq = r_irq;
`else
  assign w_irq = 1'b0;
`endif

  always_comb begin
    w_readmux = '0;
    case (h_address)
      c_addr_ctrl:   w_readmux[c_ctrl_run] = r_run;
      c_addr_delay:  w_readmux[15:0] = r_delay;
      c_addr_status: w_readmux = pack_status(w_count, w_empty, w_full, r_ovf, r_undr,
                                             w_irq, r_state);
      default:       w_readmux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_run          <= 1'b0;
      r_delay        <= '0;
      r_ovf          <= 1'b0;
      r_undr         <= 1'b0;
      r_req_prev     <= 1'b0;
      r_fe_write     <= 1'b0;
      r_fe_writedata <= '0;
      r_readdata     <= '0;
    end else begin
      r_req_prev <= fe_req;
      r_fe_write <= w_issue;
      if (w_issue) r_fe_writedata <= {24'b0, w_head};
      if (h_write && (h_address == c_addr_ctrl))  r_run   <= h_writedata[c_ctrl_run];
      if (h_write && (h_address == c_addr_delay)) r_delay <= h_writedata[15:0];
      if (w_flush || w_clr)  r_ovf <= 1'b0;
      else if (w_drop)       r_ovf <= 1'b1;
      if (w_flush || w_clr)  r_undr <= 1'b0;
      else if (w_set_undr)   r_undr <= 1'b1;
      if (h_read) r_readdata <= w_readmux;
    end
  end

  assign h_readdata   = r_readdata;
  assign fe_write     = r_fe_write;
  assign fe_writedata = r_fe_writedata;
  assign irq          = w_irq;

endmodule

`default_nettype wire

// File: tb/tb_ptr_feeder.sv
//------------------------------------------------------------------------------
// Module   : tb_ptr_feeder
// Brief    : Directed self-checking bench for ptr_feeder.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_ptr_feeder;

`ifdef PTR_FEEDER_IRQ_EN
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif

  localparam logic [1:0] A_DATA = 2'd0, A_CTRL = 2'd1, A_DELAY = 2'd2, A_STAT = 2'd3;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        h_write = 1'b0;
  logic        h_read = 1'b0;
  logic [1:0]  h_address = 2'd0;
  logic [31:0] h_writedata = '0;
  logic [31:0] h_readdata;
  logic        fe_req = 1'b0;
  logic        fe_write;
  logic [31:0] fe_writedata;
  logic        irq;

  int tests_run = 0;
  int tests_failed = 0;

  ptr_feeder dut (
    .clk          (clk),
    .reset        (reset),
    .h_write      (h_write),
    .h_read       (h_read),
    .h_address    (h_address),
    .h_writedata  (h_writedata),
    .h_readdata   (h_readdata),
    .fe_req       (fe_req),
    .fe_write     (fe_write),
    .fe_writedata (fe_writedata),
    .irq          (irq)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] exp_status(input int cnt, input bit ovf, input bit undr,
                                             input bit run, input int st);
    logic [31:0] s;
    s        = '0;
    s[4:0]   = cnt[4:0];
    s[5]     = (cnt == 0);
    s[6]     = (cnt == 16);
    s[7]     = ovf;
    s[8]     = undr;
    s[9]     = IRQ_ON && run && (cnt <= 4);
    s[12:10] = st[2:0];
    return s;
  endfunction

  task automatic host_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    h_address = a; h_writedata = d; h_write = 1'b1;
    @(negedge clk);
    h_write = 1'b0;
  endtask

  task automatic host_read(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    h_address = a; h_read = 1'b1;
    @(negedge clk);
    h_read = 1'b0;
    d = h_readdata;
  endtask

  // lat counts edges after the one that first samples fe_req high
  task automatic request_frame(output int lat, output logic [31:0] data, output bit one_cycle);
    lat = -1; data = '0; one_cycle = 1'b0;
    @(negedge clk);
    fe_req = 1'b1;
    for (int k = 0; k < 300; k++) begin
      @(posedge clk); #1;
      if (fe_write) begin
        lat = k; data = fe_writedata;
        break;
      end
    end
    @(posedge clk); #1;
    one_cycle = !fe_write;
    @(negedge clk);
    fe_req = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    #1;
    tests_run++;
    if ({fe_write, fe_writedata, irq, h_readdata} !== 66'd0) begin
      $display("FAIL reset_outputs: got fe_write=%b fe_writedata=%h irq=%b readdata=%h required all zero",
               fe_write, fe_writedata, irq, h_readdata);
      tests_failed++;
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    host_read(A_STAT, d);
    tests_run++;
    if (d !== 32'h20) begin
      $display("FAIL reset_status: got %h required %h", d, 32'h20); tests_failed++;
    end
    host_read(A_CTRL, d);
    tests_run++;
    if (d !== 32'h0) begin
      $display("FAIL reset_ctrl: got %h required 0", d); tests_failed++;
    end
  endtask

  task automatic test_basic();
    int lat; logic [31:0] data; bit oc; logic [31:0] d;
    host_write(A_DATA, 32'o372);
    host_write(A_DATA, 32'o373);
    host_write(A_DELAY, 32'd0);
    host_write(A_CTRL, 32'h1);
    request_frame(lat, data, oc);
    tests_run++;
    if (lat !== 2 || data !== 32'o372 || !oc) begin
      $display("FAIL basic_frame1: got lat=%0d data=%h one_cycle=%b required lat=2 data=%h one_cycle=1",
               lat, data, oc, 32'o372);
      tests_failed++;
    end
    request_frame(lat, data, oc);
    tests_run++;
    if (lat !== 2 || data !== 32'o373 || !oc) begin
      $display("FAIL basic_frame2: got lat=%0d data=%h one_cycle=%b required lat=2 data=%h one_cycle=1",
               lat, data, oc, 32'o373);
      tests_failed++;
    end
    host_read(A_STAT, d);
    tests_run++;
    if (d !== exp_status(0, 0, 0, 1, 0)) begin
      $display("FAIL basic_status: got %h required %h", d, exp_status(0, 0, 0, 1, 0));
      tests_failed++;
    end
  endtask

  task automatic test_delay_hold();
    int lat; int pulses; logic [31:0] data; logic [31:0] d;
    host_write(A_DELAY, 32'd5);
    host_write(A_DATA, 32'h55);
    host_write(A_DATA, 32'h66);
    lat = -1; pulses = 0; data = '0;
    @(negedge clk);
    fe_req = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (fe_write) begin
        pulses++;
        if (lat < 0) begin lat = k; data = fe_writedata; end
      end
    end
    @(negedge clk);
    fe_req = 1'b0;
    tests_run++;
    if (lat !== 7 || data !== 32'h55 || pulses !== 1) begin
      $display("FAIL delay5_frame: got lat=%0d data=%h pulses=%0d required lat=7 data=55 pulses=1",
               lat, data, pulses);
      tests_failed++;
    end
    host_read(A_STAT, d);
    tests_run++;
    if (d !== exp_status(1, 0, 0, 1, 0)) begin
      $display("FAIL delay5_status: got %h required %h", d, exp_status(1, 0, 0, 1, 0));
      tests_failed++;
    end
    host_read(A_DELAY, d);
    tests_run++;
    if (d !== 32'd5) begin
      $display("FAIL delay_readback: got %h required 5", d); tests_failed++;
    end
    host_write(A_CTRL, 32'h3);
    host_write(A_DELAY, 32'd0);
  endtask

  task automatic test_starve();
    int lat; logic [31:0] data; logic [31:0] d;
    @(negedge clk); fe_req = 1'b1;
    @(negedge clk); fe_req = 1'b0;
    repeat (4) @(negedge clk);
    host_read(A_STAT, d);
    tests_run++;
    if (d !== exp_status(0, 0, 1, 1, 3)) begin
      $display("FAIL starve_status: got %h required %h", d, exp_status(0, 0, 1, 1, 3));
      tests_failed++;
    end
    @(negedge clk);
    h_address = A_DATA; h_writedata = 32'o134; h_write = 1'b1;
    @(posedge clk); #1;
    h_write = 1'b0;
    lat = -1; data = '0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (fe_write) begin lat = k; data = fe_writedata; break; end
    end
    tests_run++;
    if (lat !== 2 || data !== 32'o134) begin
      $display("FAIL starve_release: got lat=%0d data=%h required lat=2 data=%h", lat, data, 32'o134);
      tests_failed++;
    end
    host_read(A_STAT, d);
    tests_run++;
    if (d !== exp_status(0, 0, 1, 1, 0)) begin
      $display("FAIL starve_after: got %h required %h", d, exp_status(0, 0, 1, 1, 0));
      tests_failed++;
    end
    host_write(A_CTRL, 32'h5);
    host_read(A_STAT, d);
    tests_run++;
    if (d !== exp_status(0, 0, 0, 1, 0)) begin
      $display("FAIL clear_sticky: got %h required %h", d, exp_status(0, 0, 0, 1, 0));
      tests_failed++;
    end
  endtask

  task automatic test_full();
    int lat; logic [31:0] data; bit oc; logic [31:0] d; int bad;
    host_write(A_CTRL, 32'h0);
    for (int i = 0; i < 17; i++) host_write(A_DATA, 32'h10 + i);
    host_read(A_STAT, d);
    tests_run++;
    if (d !== exp_status(16, 1, 0, 0, 0)) begin
      $display("FAIL full_status: got %h required %h", d, exp_status(16, 1, 0, 0, 0));
      tests_failed++;
    end
    host_write(A_CTRL, 32'h2);
    host_read(A_STAT, d);
    tests_run++;
    if (d !== exp_status(0, 0, 0, 0, 0)) begin
      $display("FAIL flush_status: got %h required %h", d, exp_status(0, 0, 0, 0, 0));
      tests_failed++;
    end
    for (int i = 0; i < 17; i++) host_write(A_DATA, 32'h20 + i);
    host_write(A_CTRL, 32'h1);
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      request_frame(lat, data, oc);
      if (lat !== 2 || data !== 32'h20 + i) begin
        bad++;
        $display("FAIL drain_frame%0d: got lat=%0d data=%h required lat=2 data=%h",
                 i, lat, data, 32'h20 + i);
      end
    end
    tests_run++;
    if (bad != 0) tests_failed++;
    host_read(A_STAT, d);
    tests_run++;
    if (d !== exp_status(0, 1, 0, 1, 0)) begin
      $display("FAIL drain_status: got %h required %h", d, exp_status(0, 1, 0, 1, 0));
      tests_failed++;
    end
    host_write(A_CTRL, 32'h3);
  endtask

  task automatic test_flush_issue();
    int pulses; logic [31:0] d;
    host_write(A_DATA, 32'h77);
    pulses = 0;
    @(negedge clk); fe_req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    h_address = A_CTRL; h_writedata = 32'h3; h_write = 1'b1;
    @(posedge clk); #1;
    h_write = 1'b0; fe_req = 1'b0;
    if (fe_write) pulses++;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (fe_write) pulses++;
    end
    tests_run++;
    if (pulses !== 0) begin
      $display("FAIL flush_in_issue_pulses: got %0d required 0", pulses); tests_failed++;
    end
    host_read(A_STAT, d);
    tests_run++;
    if (d !== exp_status(0, 0, 0, 1, 0)) begin
      $display("FAIL flush_in_issue_status: got %h required %h", d, exp_status(0, 0, 0, 1, 0));
      tests_failed++;
    end
  endtask

  task automatic test_reset_midframe();
    int pulses; logic [31:0] d;
    host_write(A_DELAY, 32'd100);
    host_write(A_DATA, 32'h99);
    @(negedge clk); fe_req = 1'b1;
    @(negedge clk); fe_req = 1'b0;
    repeat (10) @(negedge clk);
    host_read(A_STAT, d);
    tests_run++;
    if (d !== exp_status(1, 0, 0, 1, 1)) begin
      $display("FAIL pace_status: got %h required %h", d, exp_status(1, 0, 0, 1, 1));
      tests_failed++;
    end
    @(negedge clk); reset = 1'b0;
    #1;
    tests_run++;
    if ({fe_write, irq, h_readdata} !== 34'd0) begin
      $display("FAIL async_reset: got fe_write=%b irq=%b readdata=%h required all zero",
               fe_write, irq, h_readdata);
      tests_failed++;
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    pulses = 0;
    for (int k = 0; k < 120; k++) begin
      @(posedge clk); #1;
      if (fe_write) pulses++;
    end
    tests_run++;
    if (pulses !== 0) begin
      $display("FAIL reset_discard: got %0d pulses required 0", pulses); tests_failed++;
    end
    host_read(A_DELAY, d);
    tests_run++;
    if (d !== 32'd0) begin
      $display("FAIL reset_delay: got %h required 0", d); tests_failed++;
    end
    host_read(A_STAT, d);
    tests_run++;
    if (d !== 32'h20) begin
      $display("FAIL reset_status2: got %h required 20", d); tests_failed++;
    end
  endtask

  task automatic test_irq();
`ifdef PTR_FEEDER_IRQ_EN
    host_write(A_CTRL, 32'h3);
    for (int i = 0; i < 4; i++) host_write(A_DATA, 32'h40 + i);
    @(negedge clk);
    tests_run++;
    if (irq !== 1'b1) begin
      $display("FAIL irq_at_4: got %b required 1", irq); tests_failed++;
    end
    host_write(A_DATA, 32'h44);
    @(negedge clk);
    tests_run++;
    if (irq !== 1'b0) begin
      $display("FAIL irq_at_5: got %b required 0", irq); tests_failed++;
    end
`else
    host_write(A_CTRL, 32'h3);
    repeat (2) @(negedge clk);
    tests_run++;
    if (irq !== 1'b0) begin
      $display("FAIL irq_disabled: got %b required 0", irq); tests_failed++;
    end
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_delay_hold();
    test_starve();
    test_full();
    test_flush_issue();
    test_reset_midframe();
    test_irq();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

`default_nettype wire
